// File: rtl/block_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// block_spawn_scheduler
//
// Sequences the obstacle-block datapath for one level. Blocks are released one
// at a time on frame ticks, retired when their end-of-track flag arrives, and
// the whole level freezes when a ball collides with something. Also keeps the
// per-level frame and seconds counters.
//
// Ports
//   Clk          system clock (50 MHz)
//   Reset        synchronous, active-high reset
//   frame_clk    VGA vertical sync, asynchronous to Clk, active low
//   start        one-cycle pulse: begin or restart a level
//   abort        one-cycle pulse: return to IDLE
//   collision    per-ball collision flags, level-sensitive
//   end_level    per-block "reached end of track" flags, level-sensitive
//   block_ready  per-block enable, high while the block is in flight
//   busy         high in SPAWN, DRAIN or HALT
//   level_done   one-cycle pulse when the last block retires
//   halted       high in HALT
//   seconds      elapsed level seconds, saturating at 1023
// -----------------------------------------------------------------------------
module block_spawn_scheduler #(
  parameter int NUM_BLOCKS       = 10,
  parameter int FRAMES_PER_SPAWN = 45,
  parameter int FRAMES_PER_SEC   = 60
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_clk,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            collision,
  input  logic [NUM_BLOCKS-1:0] end_level,
  output logic [NUM_BLOCKS-1:0] block_ready,
  output logic                  busy,
  output logic                  level_done,
  output logic                  halted,
  output logic [9:0]            seconds
);

  localparam int               IDX_W        = $clog2(NUM_BLOCKS + 1);
  localparam logic [7:0]       SPAWN_RELOAD = 8'(FRAMES_PER_SPAWN - 1);
  localparam logic [7:0]       SEC_WRAP     = 8'(FRAMES_PER_SEC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [9:0]       SEC_MAX      = 10'd1023;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_DRAIN,
    S_HALT,
    S_DONE
  } state_e;

  // Frame tick recovery: two synchroniser flops, one edge-history flop and a
  // registered edge pulse, so tick_q rises on the third Clk edge after the
  // physical falling edge of frame_clk.
  logic fsync1_q, fsync2_q, fsync3_q, tick_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsync1_q <= 1'b0;
      fsync2_q <= 1'b0;
      fsync3_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      fsync1_q <= frame_clk;
      fsync2_q <= fsync1_q;
      fsync3_q <= fsync2_q;
      tick_q   <= fsync3_q & ~fsync2_q;
    end
  end

  // Level control state
  state_e                  state_q, state_d;
  logic [NUM_BLOCKS-1:0]   ready_q, ready_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7:0]              spawn_cnt_q, spawn_cnt_d;
  logic                    first_q, first_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;
  logic [9:0]              sec_q, sec_d;
  logic                    done_q, done_d;
  logic                    active;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      ready_q     <= '0;
      idx_q       <= '0;
      spawn_cnt_q <= '0;
      first_q     <= 1'b0;
      frame_cnt_q <= '0;
      sec_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      idx_q       <= idx_d;
      spawn_cnt_q <= spawn_cnt_d;
      first_q     <= first_d;
      frame_cnt_q <= frame_cnt_d;
      sec_q       <= sec_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    idx_d       = idx_q;
    spawn_cnt_d = spawn_cnt_q;
    first_d     = first_q;
    frame_cnt_d = frame_cnt_q;
    sec_d       = sec_q;
    done_d      = 1'b0;
    active      = (state_q == S_SPAWN) || (state_q == S_DRAIN);

    if (abort) begin
      state_d = S_IDLE;
      ready_d = '0;
    end else if (active && (|collision)) begin
      // Freeze everything exactly as it stood before this cycle; any release
      // or retirement arriving together with the collision is dropped.
      state_d = S_HALT;
    end else if (start) begin
      state_d     = S_SPAWN;
      ready_d     = '0;
      idx_d       = '0;
      spawn_cnt_d = SPAWN_RELOAD;
      first_d     = 1'b1;
      frame_cnt_d = '0;
      sec_d       = '0;
    end else if (active) begin
      // Retire first so a release of the same index in this cycle wins.
      ready_d = ready_q & ~end_level;

      if (tick_q) begin
        if (frame_cnt_q == SEC_WRAP) begin
          frame_cnt_d = '0;
          if (sec_q != SEC_MAX) begin
            sec_d = sec_q + 10'd1;
          end
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end

      if ((state_q == S_SPAWN) && tick_q) begin
        // The first tick of a level releases immediately; later releases
        // wait for the spawn countdown to expire.
        if (first_q || (spawn_cnt_q == 8'd0)) begin
          for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              ready_d[i] = 1'b1;
            end
          end
          idx_d       = idx_q + 1'b1;
          spawn_cnt_d = SPAWN_RELOAD;
          first_d     = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DRAIN;
          end
        end else begin
          spawn_cnt_d = spawn_cnt_q - 8'd1;
        end
      end

      // All blocks have been released by the time DRAIN is entered, so an
      // empty in-flight set means the level is finished.
      if ((state_q == S_DRAIN) && (ready_q == '0)) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end
  end

  assign block_ready = ready_q;
  assign busy        = (state_q == S_SPAWN) || (state_q == S_DRAIN) || (state_q == S_HALT);
  assign halted      = (state_q == S_HALT);
  assign level_done  = done_q;
  assign seconds     = sec_q;

endmodule

// File: tb/tb_block_spawn_scheduler.sv
module tb_block_spawn_scheduler;
  localparam int NB = 10, FPS = 4, FPSEC = 60;
  localparam int M_IDLE = 0, M_SPAWN = 1, M_DRAIN = 2, M_HALT = 3, M_DONE = 4;

  logic Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0] collision = 2'b00;
  logic [NB-1:0] end_level = '0;
  logic [NB-1:0] block_ready;
  logic busy, level_done, halted;
  logic [9:0] seconds;

  // Second instance used only for seconds saturation with a fast frame clock.
  logic frame_clk1 = 1'b1, start1 = 1'b0;
  logic [1:0] collision1 = 2'b00, end_level1 = 2'b00, block_ready1;
  logic busy1, level_done1, halted1;
  logic [9:0] seconds1;

  int n_chk = 0, n_fail = 0;

  block_spawn_scheduler #(.NUM_BLOCKS(NB), .FRAMES_PER_SPAWN(FPS), .FRAMES_PER_SEC(FPSEC)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start), .abort(abort),
    .collision(collision), .end_level(end_level), .block_ready(block_ready),
    .busy(busy), .level_done(level_done), .halted(halted), .seconds(seconds));

  block_spawn_scheduler #(.NUM_BLOCKS(2), .FRAMES_PER_SPAWN(255), .FRAMES_PER_SEC(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk1), .start(start1), .abort(abort),
    .collision(collision1), .end_level(end_level1), .block_ready(block_ready1),
    .busy(busy1), .level_done(level_done1), .halted(halted1), .seconds(seconds1));

  always #5 Clk = ~Clk;

  // Frame clocks: 20-cycle period for the main instance, 4-cycle for dut1.
  int fcnt = 0, fcnt1 = 0;
  bit fc1_en = 1'b0;
  always @(negedge Clk) begin
    fcnt = (fcnt + 1) % 20;
    frame_clk = (fcnt < 10);
    if (fc1_en) begin
      fcnt1 = (fcnt1 + 1) % 4;
      frame_clk1 = (fcnt1 < 2);
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks ticks seen per level and derives releases and
  // seconds arithmetically from those counts.
  int m_st = M_IDLE, m_spawn_t = 0, m_lvl_t = 0, mtick = 0;
  logic [NB-1:0] m_rdy = '0;
  bit m_ld = 1'b0, m_prev = 1'b0;
  bit [2:0] m_pipe = 3'b000;

  always @(posedge Clk) begin
    bit tk;
    int st, b;
    logic [NB-1:0] nxt;
    // A fall first seen at a sample edge acts on the third edge after it.
    tk = m_pipe[2];
    m_pipe = {m_pipe[1:0], m_prev & ~frame_clk};
    m_prev = frame_clk;
    st = m_st;
    m_ld = 1'b0;
    if (Reset) begin
      m_st = M_IDLE; m_rdy = '0; m_spawn_t = 0; m_lvl_t = 0;
      m_pipe = 3'b000; m_prev = 1'b0; tk = 1'b0;
    end else if (abort) begin
      m_st = M_IDLE; m_rdy = '0;
    end else if (collision != 2'b00 && (st == M_SPAWN || st == M_DRAIN)) begin
      m_st = M_HALT;
    end else if (start) begin
      m_st = M_SPAWN; m_rdy = '0; m_spawn_t = 0; m_lvl_t = 0;
    end else if (st == M_SPAWN || st == M_DRAIN) begin
      nxt = m_rdy & ~end_level;
      if (tk) begin
        m_lvl_t++;
        if (st == M_SPAWN) begin
          m_spawn_t++;
          if ((m_spawn_t - 1) % FPS == 0) begin
            b = (m_spawn_t - 1) / FPS;
            nxt = nxt | (NB'(1) << b);
            if (b == NB - 1) m_st = M_DRAIN;
          end
        end
      end
      if (st == M_DRAIN && m_rdy == '0) begin
        m_st = M_DONE; m_ld = 1'b1;
      end
      m_rdy = nxt;
    end
    if (tk) mtick++;
  end

  bit cmp_en = 1'b0;
  always @(negedge Clk) begin
    if (cmp_en) begin
      check("cyc_block_ready", int'(block_ready), int'(m_rdy));
      check("cyc_busy", int'(busy), int'(m_st == M_SPAWN || m_st == M_DRAIN || m_st == M_HALT));
      check("cyc_halted", int'(halted), int'(m_st == M_HALT));
      check("cyc_level_done", int'(level_done), int'(m_ld));
      check("cyc_seconds", int'(seconds), (m_lvl_t / FPSEC > 1023) ? 1023 : m_lvl_t / FPSEC);
    end
  end

  task automatic pulse_start();
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0;
  endtask

  task automatic wait_lvl(input int n);
    int c = 0;
    while (m_lvl_t < n && c < 6000) begin
      @(negedge Clk); c++;
    end
    check("lvl_tick_wait", m_lvl_t, n);
  endtask

  task automatic pulse_end(input logic [NB-1:0] m);
    @(negedge Clk); end_level = m;
    @(negedge Clk); end_level = '0;
  endtask

  initial begin
    int base, c;
    repeat (3) @(posedge Clk);
    cmp_en = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    @(negedge Clk);
    check("rst_ready", int'(block_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_done", int'(level_done), 0);
    check("rst_seconds", int'(seconds), 0);

    // Basic release cadence
    pulse_start();
    check("start_ready", int'(block_ready), 0);
    check("start_busy", int'(busy), 1);
    wait_lvl(1);  check("tick1_ready", int'(block_ready), 10'h001);
    wait_lvl(5);  check("tick5_ready", int'(block_ready), 10'h003);
    wait_lvl(37); check("tick37_ready", int'(block_ready), 10'h3FF);
    check("drain_busy", int'(busy), 1);

    // Restart, retire each block two ticks after its release
    pulse_start();
    check("restart_ready", int'(block_ready), 0);
    for (int k = 0; k < NB; k++) begin
      wait_lvl(3 + 4 * k);
      check("inflight_one", int'(block_ready), 1 << k);
      pulse_end(NB'(1) << k);
      check("retired", int'(block_ready), 0);
    end
    check("done_not_yet", int'(level_done), 0);
    @(negedge Clk);
    check("level_done_pulse", int'(level_done), 1);
    check("done_busy", int'(busy), 0);
    @(negedge Clk);
    check("level_done_one_cycle", int'(level_done), 0);

    // Collision with three blocks in flight
    pulse_start();
    wait_lvl(12); check("tick12_ready", int'(block_ready), 10'h007);
    @(negedge Clk); collision = 2'b01;
    @(negedge Clk); collision = 2'b00;
    check("halt_halted", int'(halted), 1);
    check("halt_ready", int'(block_ready), 10'h007);
    base = mtick; c = 0;
    while (mtick - base < 100 && c < 3000) begin @(negedge Clk); c++; end
    check("halt_tick_wait", mtick - base, 100);
    check("halt_hold_ready", int'(block_ready), 10'h007);
    check("halt_hold_seconds", int'(seconds), 0);
    check("halt_hold_halted", int'(halted), 1);
    pulse_start();
    check("halt_restart_ready", int'(block_ready), 0);
    check("halt_restart_halted", int'(halted), 0);
    wait_lvl(1); check("after_halt_first", int'(block_ready), 10'h001);

    // Seconds over 200 ticks
    wait_lvl(200);
    check("seconds_200", int'(seconds), 3);
    check("ready_200", int'(block_ready), 10'h3FF);

    // start + collision together in SPAWN: collision wins
    pulse_start();
    wait_lvl(5); check("e_tick5", int'(block_ready), 10'h003);
    @(negedge Clk); start = 1'b1; collision = 2'b01;
    @(negedge Clk); start = 1'b0; collision = 2'b00;
    check("sc_halted", int'(halted), 1);
    check("sc_ready", int'(block_ready), 10'h003);
    pulse_start();
    wait_lvl(1);
    @(negedge Clk); abort = 1'b1; collision = 2'b10;
    @(negedge Clk); abort = 1'b0; collision = 2'b00;
    check("ac_busy", int'(busy), 0);
    check("ac_ready", int'(block_ready), 0);
    check("ac_halted", int'(halted), 0);

    // Reset mid-DRAIN
    pulse_start();
    wait_lvl(37); check("f_full", int'(block_ready), 10'h3FF);
    pulse_end(10'h3F0);
    check("f_four_left", int'(block_ready), 10'h00F);
    check("f_busy", int'(busy), 1);
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    check("mid_rst_ready", int'(block_ready), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_halted", int'(halted), 0);
    check("mid_rst_done", int'(level_done), 0);
    check("mid_rst_seconds", int'(seconds), 0);
    pulse_end(10'h3FF);
    check("idle_end_ready", int'(block_ready), 0);
    check("idle_end_done", int'(level_done), 0);
    @(negedge Clk);
    check("idle_end_done2", int'(level_done), 0);
    check("idle_end_busy", int'(busy), 0);

    // Seconds saturation on the fast instance
    @(negedge Clk); Reset = 1'b1; fc1_en = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    @(negedge Clk); start1 = 1'b1;
    @(negedge Clk); start1 = 1'b0;
    repeat (4700) @(negedge Clk);
    check("sat_seconds", int'(seconds1), 1023);
    check("sat_ready", int'(block_ready1), 3);
    check("sat_busy", int'(busy1), 1);
    repeat (200) @(negedge Clk);
    check("sat_hold", int'(seconds1), 1023);
    check("sat_halted", int'(halted1), 0);
    check("sat_done", int'(level_done1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
